// File: rtl/vend_pkg.sv
// Shared types and defaults for the vending payment controller.
//   state_e       : session FSM states (IDLE, PAY, SETTLE, DONE)
//   AMT_W_DEF     : default width of price / paid total / change
//   COIN_W        : width of a single coin value (1..7, 0 ignored)
//   TIMEOUT_S_DEF : default session length in seconds
//   SECS_W        : width of the seconds-remaining counter (holds 1..63)
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAY    = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int AMT_W_DEF     = 6;
  localparam int COIN_W        = 3;
  localparam int TIMEOUT_S_DEF = 30;
  localparam int SECS_W        = 6;

endpackage

// File: rtl/vend_pay_ctrl_if.sv
// Bundle of session control, coin and result signals between the payment
// controller and its neighbours (product-select FSM, coin acceptor,
// dispenser and display).
//   master : drives start/price/coin_valid/coin_val/cancel/ack, reads results
//   slave  : the payment controller itself
interface vend_pay_ctrl_if #(
  parameter int AMT_W = vend_pkg::AMT_W_DEF
) ();

  logic                        start;
  logic [AMT_W-1:0]            price;
  logic                        coin_valid;
  logic [vend_pkg::COIN_W-1:0] coin_val;
  logic                        cancel;
  logic                        ack;
  logic                        busy;
  logic                        coin_rej;
  logic [AMT_W-1:0]            paid;
  logic [3:0]                  paid_tens;
  logic [3:0]                  paid_ones;
  logic [vend_pkg::SECS_W-1:0] secs_left;
  logic                        done;
  logic                        success;
  logic [AMT_W-1:0]            change;

  modport master (
    output start, price, coin_valid, coin_val, cancel, ack,
    input  busy, coin_rej, paid, paid_tens, paid_ones, secs_left,
           done, success, change
  );

  modport slave (
    input  start, price, coin_valid, coin_val, cancel, ack,
    output busy, coin_rej, paid, paid_tens, paid_ones, secs_left,
           done, success, change
  );

endinterface

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
//   clk, rst : clock, synchronous active-high reset
//   clear_i  : hold the count at 0 (count restarts from 0 once released)
//   tick_o   : high during the cycle in which the count equals TICK_DIV-1
module sec_tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  // Next count: wrap at LAST, forced to zero while cleared.
  always_comb begin
    if (clear_i) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register; tick is decoded from the next count so it is a flop
  // that is high exactly while cnt_q sits at LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= (TICK_DIV == 1);
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/vend_pay_ctrl.sv
// Vending payment session controller: latches the price on start, accepts
// coins for TIMEOUT_S seconds (or until cancel), then settles success/change
// and holds the result until ack.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vend_pay_ctrl_if.slave (start/price, coins, cancel, ack in;
//              busy, coin_rej, paid + BCD digits, secs_left, done,
//              success, change out)
// Optional build macro VEND_PAY_AUTO_SETTLE_EN: when defined, a session also
// settles as soon as the registered paid total covers the price.
module vend_pay_ctrl
  import vend_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int TIMEOUT_S = TIMEOUT_S_DEF,
  parameter int AMT_W     = AMT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  vend_pay_ctrl_if.slave bus
);

  localparam int SUM_W = AMT_W + 1;
  localparam logic [AMT_W-1:0] TEN = AMT_W'(10);

  state_e            state_q;
  logic [AMT_W-1:0]  price_q, paid_q, change_q;
  logic [SECS_W-1:0] secs_q;
  logic              busy_q, coin_rej_q, done_q, success_q;
  logic              tick_s, clear_s, coin_s, ovf_s, timeout_s, settle_req_s;
  logic [SUM_W-1:0]  sum_s;

  // Prescaler runs only while a session is collecting coins.
  assign clear_s = (state_q != PAY);

  sec_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_sec_tick (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_s),
    .tick_o  (tick_s)
  );

  // Coin qualification, overflow detect and settle request.
  always_comb begin
    coin_s    = bus.coin_valid && (bus.coin_val != COIN_W'(0));
    sum_s     = {1'b0, paid_q} + SUM_W'(bus.coin_val);
    ovf_s     = sum_s[AMT_W];
    timeout_s = tick_s && (secs_q == SECS_W'(1));
`ifdef VEND_PAY_AUTO_SETTLE_EN
    settle_req_s = bus.cancel || timeout_s || (paid_q >= price_q);
`else
    settle_req_s = bus.cancel || timeout_s;
`endif
  end

  // Session FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      price_q    <= {AMT_W{1'b0}};
      paid_q     <= {AMT_W{1'b0}};
      change_q   <= {AMT_W{1'b0}};
      secs_q     <= {SECS_W{1'b0}};
      busy_q     <= 1'b0;
      coin_rej_q <= 1'b0;
      done_q     <= 1'b0;
      success_q  <= 1'b0;
    end else begin
      coin_rej_q <= 1'b0;
      case (state_q)
        IDLE: begin
          coin_rej_q <= coin_s;
          if (bus.start) begin
            state_q <= PAY;
            price_q <= bus.price;
            paid_q  <= {AMT_W{1'b0}};
            secs_q  <= SECS_W'(TIMEOUT_S);
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        PAY: begin
          // A coin in the terminating cycle is still counted.
          if (coin_s) begin
            if (ovf_s) begin
              coin_rej_q <= 1'b1;
            end else begin
              paid_q <= sum_s[AMT_W-1:0];
            end
          end
          if (tick_s) begin
            secs_q <= secs_q - SECS_W'(1);
          end
          if (settle_req_s) begin
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          coin_rej_q <= coin_s;
          if (paid_q >= price_q) begin
            success_q <= 1'b1;
            change_q  <= paid_q - price_q;
          end else begin
            success_q <= 1'b0;
            change_q  <= paid_q;
          end
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          coin_rej_q <= coin_s;
          if (bus.ack) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            success_q <= 1'b0;
            change_q  <= {AMT_W{1'b0}};
            paid_q    <= {AMT_W{1'b0}};
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.coin_rej  = coin_rej_q;
  assign bus.paid      = paid_q;
  assign bus.paid_tens = 4'(paid_q / TEN);
  assign bus.paid_ones = 4'(paid_q % TEN);
  assign bus.secs_left = secs_q;
  assign bus.done      = done_q;
  assign bus.success   = success_q;
  assign bus.change    = change_q;

endmodule

// File: tb/tb_vend_pay_ctrl.sv
// Self-checking bench for vend_pay_ctrl (TICK_DIV=4, TIMEOUT_S=30, AMT_W=6).
// Expected values come from a session-level model: paid is a running integer
// sum with the overflow rule, seconds left are derived from cycles spent
// paying, and the settle outcome is plain integer arithmetic.
module tb_vend_pay_ctrl;

  localparam int TD = 4;
  localparam int TO = 30;
  localparam int AW = 6;
  localparam int NPAY = TO * TD;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;

  bit   cvld [NPAY];
  int   cval [NPAY];

  vend_pay_ctrl_if #(.AMT_W(AW)) bus ();

  vend_pay_ctrl #(
    .TICK_DIV  (TD),
    .TIMEOUT_S (TO),
    .AMT_W     (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // busy[29] rej[28] done[27] succ[26] paid[25:20] tens[19:16] ones[15:12]
  // secs[11:6] change[5:0]
  logic [29:0] obs;
  assign obs = {bus.busy, bus.coin_rej, bus.done, bus.success, bus.paid,
                bus.paid_tens, bus.paid_ones, bus.secs_left, bus.change};

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.price = '0; bus.coin_valid = 1'b0;
    bus.coin_val = '0; bus.cancel = 1'b0; bus.ack = 1'b0;
  endtask

  task automatic clear_sched();
    for (int k = 0; k < NPAY; k++) begin
      cvld[k] = 1'b0;
      cval[k] = 0;
    end
  endtask

  // Full session: start, coins per schedule, optional cancel / stray start,
  // settle, a coin and a start while DONE, then ack back to IDLE.
  task automatic run_session(input string nm, input int price, input int cancel_k,
                             input int restart_k);
    int paid, k, secs_end, chg;
    bit rej, settle, succ;
    logic [29:0] exp_v;
    logic [23:0] got_m;
    bus.start = 1'b1; bus.price = 6'(price);
    tick_clk();
    idle_inputs();
    paid = 0; rej = 1'b0; settle = 1'b0; k = 0;
    while (!settle) begin
      exp_v = {1'b1, rej, 2'b00, 6'(paid), 4'(paid / 10), 4'(paid % 10),
               6'(TO - k / TD), 6'd0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s pay k=%0d: got %h expected %h", nm, k, obs, exp_v);
      end
      bus.coin_valid = cvld[k]; bus.coin_val = 3'(cval[k]);
      bus.cancel = (k == cancel_k); bus.start = (k == restart_k); bus.price = 6'd5;
`ifdef VEND_PAY_AUTO_SETTLE_EN
      settle = (k == cancel_k) || (k == NPAY - 1) || (paid >= price);
`else
      settle = (k == cancel_k) || (k == NPAY - 1);
`endif
      rej = 1'b0;
      if (cvld[k] && cval[k] != 0) begin
        if (paid + cval[k] > (1 << AW) - 1) rej = 1'b1;
        else paid += cval[k];
      end
      tick_clk();
      idle_inputs();
      k++;
    end
    secs_end = TO - k / TD;
    succ = (paid >= price);
    chg  = succ ? paid - price : paid;
    // settle cycle
    exp_v = {1'b1, rej, 2'b00, 6'(paid), 4'(paid / 10), 4'(paid % 10), 6'(secs_end), 6'd0};
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s settle: got %h expected %h", nm, obs, exp_v);
    end
    tick_clk();
    // first DONE cycle: result valid two cycles after the terminating cycle
    exp_v = {3'b001, succ, 6'(paid), 4'(paid / 10), 4'(paid % 10), 6'(secs_end), 6'(chg)};
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s done: got %h expected %h", nm, obs, exp_v);
    end
    bus.coin_valid = 1'b1; bus.coin_val = 3'd5; bus.start = 1'b1; bus.price = 6'd1;
    tick_clk();
    idle_inputs();
    exp_v = {3'b011, succ, 6'(paid), 4'(paid / 10), 4'(paid % 10), 6'(secs_end), 6'(chg)};
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s done_hold_rej: got %h expected %h", nm, obs, exp_v);
    end
    bus.ack = 1'b1;
    tick_clk();
    idle_inputs();
    got_m = {obs[29:12], obs[5:0]};
    n_cmp++;
    if (got_m !== 24'd0) begin
      n_fail++;
      $display("FAIL %s after_ack: got %h expected 000000 (secs masked)", nm, got_m);
    end
  endtask

  task automatic test_reset();
    logic [29:0] exp_v;
    rst = 1'b1;
    tick_clk();
    tick_clk();
    n_cmp++;
    if (obs !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected 0", obs);
    end
    rst = 1'b0;
    bus.coin_valid = 1'b1; bus.coin_val = 3'd3; bus.cancel = 1'b1; bus.ack = 1'b1;
    tick_clk();
    idle_inputs();
    exp_v = 30'd0;
    exp_v[28] = 1'b1;
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL idle_coin_rej: got %h expected %h", obs, exp_v);
    end
    tick_clk();
    n_cmp++;
    if (obs !== 30'd0) begin
      n_fail++;
      $display("FAIL idle_rej_one_cycle: got %h expected 0", obs);
    end
    bus.coin_valid = 1'b1; bus.coin_val = 3'd0;
    tick_clk();
    idle_inputs();
    n_cmp++;
    if (obs !== 30'd0) begin
      n_fail++;
      $display("FAIL idle_zero_coin: got %h expected 0", obs);
    end
  endtask

  task automatic test_exact_cancel();
    clear_sched();
    cvld[0] = 1'b1; cval[0] = 5; cvld[1] = 1'b1; cval[1] = 5;
    cvld[2] = 1'b1; cval[2] = 2;
    run_session("exact_cancel", 12, 5, -1);
  endtask

  task automatic test_overpay_timeout();
    clear_sched();
    cvld[0] = 1'b1; cval[0] = 7; cvld[5] = 1'b1; cval[5] = 7;
    run_session("overpay_timeout", 10, -1, -1);
  endtask

  task automatic test_underpay_cancel();
    clear_sched();
    cvld[1] = 1'b1; cval[1] = 3; cvld[3] = 1'b1; cval[3] = 4;
    run_session("underpay_cancel", 20, 6, -1);
  endtask

  task automatic test_overflow_simul();
    clear_sched();
    for (int k = 0; k < 8; k++) begin
      cvld[k] = 1'b1; cval[k] = 7;
    end
    cvld[8] = 1'b1; cval[8] = 4;
    cvld[9] = 1'b1; cval[9] = 7;
    cvld[10] = 1'b1; cval[10] = 3;
    run_session("overflow_simul", 40, 10, -1);
  endtask

  task automatic test_ignored();
    logic [6:0] got_bp;
    clear_sched();
    cvld[0] = 1'b1; cval[0] = 4; cvld[1] = 1'b1; cval[1] = 6;
    run_session("start_in_pay", 20, 4, 2);
    // reset in the middle of a session
    bus.start = 1'b1; bus.price = 6'd30;
    tick_clk();
    idle_inputs();
    bus.coin_valid = 1'b1; bus.coin_val = 3'd5;
    tick_clk();
    bus.coin_val = 3'd6;
    tick_clk();
    idle_inputs();
    got_bp = {obs[29], obs[25:20]};
    n_cmp++;
    if (got_bp !== {1'b1, 6'd11}) begin
      n_fail++;
      $display("FAIL mid_pay_paid: got %h expected %h", got_bp, {1'b1, 6'd11});
    end
    rst = 1'b1; bus.coin_valid = 1'b1; bus.coin_val = 3'd4; bus.cancel = 1'b1;
    tick_clk();
    rst = 1'b0;
    idle_inputs();
    n_cmp++;
    if (obs !== 30'd0) begin
      n_fail++;
      $display("FAIL rst_mid_pay: got %h expected 0", obs);
    end
    tick_clk();
    tick_clk();
    n_cmp++;
    if (obs !== 30'd0) begin
      n_fail++;
      $display("FAIL rst_no_refund: got %h expected 0", obs);
    end
  endtask

  task automatic test_price_zero();
    clear_sched();
    run_session("price_zero", 0, 2, -1);
  endtask

  task automatic test_auto_settle();
    clear_sched();
    cvld[0] = 1'b1; cval[0] = 4; cvld[1] = 1'b1; cval[1] = 6;
    run_session("auto_settle", 9, -1, -1);
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < NPAY; k++) begin
        cvld[k] = ($urandom_range(0, 3) == 0);
        cval[k] = int'($urandom_range(0, 7));
      end
      run_session("random", int'($urandom_range(0, 63)), int'($urandom_range(3, 140)), -1);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_exact_cancel();
    test_overpay_timeout();
    test_underpay_cancel();
    test_overflow_simul();
    test_ignored();
    test_price_zero();
    test_auto_settle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
